// File: rtl/map_port_arbiter_if.sv
// Bus bundle between the video/world_if clients, the map arbiter and the map BRAM read port.
// The arbiter binds the slave modport; the client/RAM environment binds master.
interface map_port_arbiter_if #(
    parameter int MAP_ROW_W = 8,
    parameter int MAP_COL_W = 8,
    parameter int VID_W     = 11
);
    logic                 vid_req;
    logic [VID_W-1:0]     vid_row;
    logic [VID_W-1:0]     vid_col;
    logic                 vid_valid;
    logic [1:0]           vid_pixel_out;
    logic                 wrld_req;
    logic [MAP_ROW_W-1:0] wrld_row;
    logic [MAP_COL_W-1:0] wrld_col;
    logic                 wrld_ack;
    logic [1:0]           wrld_loc_info;
    logic                 ram_en;
    logic [MAP_ROW_W-1:0] ram_row;
    logic [MAP_COL_W-1:0] ram_col;
    logic [1:0]           ram_dout;

    modport slave (
        input  vid_req, vid_row, vid_col, wrld_req, wrld_row, wrld_col, ram_dout,
        output vid_valid, vid_pixel_out, wrld_ack, wrld_loc_info, ram_en, ram_row, ram_col
    );

    modport master (
        output vid_req, vid_row, vid_col, wrld_req, wrld_row, wrld_col, ram_dout,
        input  vid_valid, vid_pixel_out, wrld_ack, wrld_loc_info, ram_en, ram_row, ram_col
    );
endinterface

// File: rtl/map_port_arbiter.sv
// Arbitrates the world-map BRAM read port between video pixel fetch and world lookups.
// Optional macro MAPARB_STARVE_EN enables the starvation counter (default: strict video priority).
module map_port_arbiter #(
    parameter int MAP_ROW_W  = 8,
    parameter int MAP_COL_W  = 8,
    parameter int VID_W      = 11,
    parameter int VID_SHIFT  = 3,
    parameter int MAP_ROWS   = 96,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 15
) (
    input logic               clk,
    input logic               reset,
    map_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WFLIGHT, WDONE} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_WRLD, TAG_VID, TAG_VZERO} tag_t;

    localparam int DEPTH = RD_LAT + 1;
    localparam int ROWS_CLAMP = (MAP_ROWS > (1 << MAP_ROW_W)) ? (1 << MAP_ROW_W) : MAP_ROWS;
    localparam logic [MAP_ROW_W:0] ROWS_LIM = (MAP_ROW_W + 1)'(ROWS_CLAMP);

    if (RD_LAT < 1 || RD_LAT > 3 || STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_param_chk
        $error("map_port_arbiter: RD_LAT or STARVE_MAX out of range");
    end

    state_t               state_q, state_d;
    tag_t                 tag_q [DEPTH];
    tag_t                 tag_in;
    logic                 ram_en_q, ram_en_d;
    logic [MAP_ROW_W-1:0] ram_row_q, ram_row_d;
    logic [MAP_COL_W-1:0] ram_col_q, ram_col_d;
    logic                 vid_valid_q, vid_valid_d;
    logic [1:0]           vid_pixel_q, vid_pixel_d;
    logic                 wrld_ack_q, wrld_ack_d;
    logic [1:0]           wrld_info_q, wrld_info_d;

    logic [MAP_ROW_W-1:0] vmap_row;
    logic [MAP_COL_W-1:0] vmap_col;
    logic                 vid_in_range;
    logic                 wrld_elig;
    logic                 grant_vid, grant_wrld;

`ifdef MAPARB_STARVE_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    logic [7:0] starve_cnt_q, starve_cnt_d;
`endif

    assign vmap_row     = MAP_ROW_W'(bus.vid_row >> VID_SHIFT);
    assign vmap_col     = MAP_COL_W'(bus.vid_col >> VID_SHIFT);
    assign vid_in_range = ({1'b0, vmap_row} < ROWS_LIM);

    // A held world request is not re-granted while its ack is still visible.
    assign wrld_elig = (state_q == IDLE) && bus.wrld_req && !wrld_ack_q;

    always_comb begin
        grant_vid  = 1'b0;
        grant_wrld = 1'b0;
`ifdef MAPARB_STARVE_EN
        starve_cnt_d = starve_cnt_q;
        if (wrld_elig && bus.vid_req) begin
            if (starve_cnt_q < STARVE_LIM) begin
                grant_vid    = 1'b1;
                starve_cnt_d = starve_cnt_q + 8'd1;
            end else begin
                grant_wrld = 1'b1;
            end
        end else if (wrld_elig) begin
            grant_wrld = 1'b1;
        end else begin
            grant_vid = bus.vid_req;
        end
        if (grant_wrld || !bus.wrld_req) begin
            starve_cnt_d = '0;
        end
`else
        grant_wrld = wrld_elig && !bus.vid_req;
        grant_vid  = bus.vid_req;
`endif
    end

    always_comb begin
        state_d   = state_q;
        ram_en_d  = 1'b0;
        ram_row_d = ram_row_q;
        ram_col_d = ram_col_q;
        tag_in    = TAG_NONE;

        if (grant_wrld) begin
            ram_en_d  = 1'b1;
            ram_row_d = bus.wrld_row;
            ram_col_d = bus.wrld_col;
            tag_in    = TAG_WRLD;
        end else if (grant_vid) begin
            if (vid_in_range) begin
                ram_en_d  = 1'b1;
                ram_row_d = vmap_row;
                ram_col_d = vmap_col;
                tag_in    = TAG_VID;
            end else begin
                tag_in = TAG_VZERO;
            end
        end

        case (state_q)
            IDLE:    if (grant_wrld) state_d = WFLIGHT;
            WFLIGHT: if (tag_q[RD_LAT] == TAG_WRLD) state_d = WDONE;
            WDONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The oldest tag stage lines up with ram_dout and steers it to its owner.
    always_comb begin
        vid_valid_d = 1'b0;
        vid_pixel_d = vid_pixel_q;
        wrld_ack_d  = 1'b0;
        wrld_info_d = wrld_info_q;
        case (tag_q[RD_LAT])
            TAG_VID: begin
                vid_valid_d = 1'b1;
                vid_pixel_d = bus.ram_dout;
            end
            TAG_VZERO: begin
                vid_valid_d = 1'b1;
                vid_pixel_d = 2'b00;
            end
            TAG_WRLD: begin
                wrld_ack_d  = 1'b1;
                wrld_info_d = bus.ram_dout;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ram_en_q    <= 1'b0;
            ram_row_q   <= '0;
            ram_col_q   <= '0;
            vid_valid_q <= 1'b0;
            vid_pixel_q <= '0;
            wrld_ack_q  <= 1'b0;
            wrld_info_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            state_q     <= state_d;
            ram_en_q    <= ram_en_d;
            ram_row_q   <= ram_row_d;
            ram_col_q   <= ram_col_d;
            vid_valid_q <= vid_valid_d;
            vid_pixel_q <= vid_pixel_d;
            wrld_ack_q  <= wrld_ack_d;
            wrld_info_q <= wrld_info_d;
            tag_q[0]    <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

`ifdef MAPARB_STARVE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    assign bus.ram_en        = ram_en_q;
    assign bus.ram_row       = ram_row_q;
    assign bus.ram_col       = ram_col_q;
    assign bus.vid_valid     = vid_valid_q;
    assign bus.vid_pixel_out = vid_pixel_q;
    assign bus.wrld_ack      = wrld_ack_q;
    assign bus.wrld_loc_info = wrld_info_q;
endmodule

// File: doc/map_port_arbiter.md
# map_port_arbiter

Shares the single read port of the world-map BRAM between the video pixel fetch path and the BOTSIM world-interface map lookups. It sits between the video/world_if logic and the map RAM. Video reads are time-critical and get default priority. A starvation counter guarantees that the simulator's req/ack lookups complete even while video reads back-to-back. Video addresses are scaled down to map coordinates internally, and all RAM-side signals are registered.

## Interface
- MAP_ROW_W, 8, map row address width
- MAP_COL_W, 8, map column address width
- VID_W, 11, video row/column width
- VID_SHIFT, 3, right shift from video coordinate to map coordinate
- MAP_ROWS, 96, valid map rows; scaled video rows >= MAP_ROWS read as 0
- RD_LAT, 1, BRAM read latency in cycles (1..3)
- STARVE_MAX, 15, consecutive video grants tolerated while world is pending (1..255)

Ports:
- clk  in  1  system clock; sole clock
- reset  in  1  asynchronous, active-high reset
- vid_req  in  1  video wants a pixel this cycle
- vid_row, vid_col  in  VID_W  video pixel coordinates
- vid_valid  out  1  vid_pixel_out holds a new pixel
- vid_pixel_out  out  2  map value for the granted video request
- wrld_req  in  1  world lookup request; held with stable address until wrld_ack
- wrld_row  in  MAP_ROW_W  world lookup row
- wrld_col  in  MAP_COL_W  world lookup column
- wrld_ack  out  1  one-cycle pulse; wrld_loc_info valid in the same cycle
- wrld_loc_info  out  2  map value for the world lookup
- ram_en  out  1  RAM read enable
- ram_row  out  MAP_ROW_W  RAM row address
- ram_col  out  MAP_COL_W  RAM column address
- ram_dout  in  2  RAM read data, valid RD_LAT cycles after ram_en

## Operation
- One RAM read per cycle at most. The arbiter samples requests each cycle and registers the grant onto ram_en/ram_row/ram_col.
- Controller states:
  - IDLE: no world lookup in flight.
  - WFLIGHT: world read issued, waiting for its data.
  - WDONE: ack cycle; returns to IDLE.
- A new world grant happens only in IDLE with wrld_req high and wrld_ack low. This prevents re-issuing a held request.
- Priority, when both requests are present in IDLE:
  - Video wins while starve_cnt < STARVE_MAX. starve_cnt increments on each such cycle.
  - When starve_cnt == STARVE_MAX, world wins and starve_cnt clears.
  - starve_cnt also clears on any world grant and whenever wrld_req is low.
- Video address scaling:
  - map_row = vid_row >> VID_SHIFT and map_col = vid_col >> VID_SHIFT, truncated to width.
  - If map_row >= MAP_ROWS, no RAM access is issued. That slot still produces vid_valid with pixel 2'b00, at the same latency as a real read.
- Return path: a tag shift register RD_LAT+1 deep (2 bits per stage: video / world) routes ram_dout to the owning output register.
- Denied video request: vid_valid stays low for that slot, and vid_pixel_out holds its last value.
- Reset values: vid_valid=0, vid_pixel_out=0, wrld_ack=0, wrld_loc_info=0, ram_en=0, ram_row=0, ram_col=0, starve_cnt=0, tags cleared, state=IDLE.
- Reset mid-operation clears all in-flight tags. A world lookup interrupted by reset is never acked; it is re-requested after reset only if the requester still holds wrld_req.

## Timing
- Request sampled at edge k → ram_en high in cycle k+1 → ram_dout valid in cycle k+1+RD_LAT → output registered, visible in cycle k+2+RD_LAT.
- With RD_LAT=1:
  - video pixel latency is 3 cycles.
  - wrld_ack arrives 3 cycles after the granting edge.
- Video throughput is 1 pixel/cycle when no world request is pending.
- Worst-case world wait is STARVE_MAX+1 cycles to grant, plus 2+RD_LAT cycles to ack.
- wrld_ack and a vid_valid for an earlier video grant may assert in the same cycle.
- Simultaneous reset and request: reset dominates; no grant occurs.

## Configuration
- MAPARB_STARVE_EN defined: starvation counter and forced world grants are enabled, as described above.
- MAPARB_STARVE_EN undefined:
  - Strict video priority; the world request is granted only in cycles with vid_req low (blanking).
  - starve_cnt logic is removed and STARVE_MAX is ignored.

## Test plan
- Reset check: assert reset asynchronously mid-cycle → all outputs 0 immediately; ram_en stays 0 for the cycle after deassert.
- Video-only stream, RD_LAT=1, VID_SHIFT=3:
  - vid_req continuous, vid_row=40, vid_col=17 → ram_row=5, ram_col=2, ram_en in cycle k+1.
  - RAM returns 2'b10 → vid_pixel_out=2'b10 with vid_valid in cycle k+3.
- Blanking service: vid_req low, wrld_req with row=7, col=9 → exactly one ram_en with 7/9; wrld_ack pulses once 3 cycles after grant with RAM value 2'b01; no second read while wrld_req is still held.
- Starvation, STARVE_MAX=4, macro defined: vid_req and wrld_req both continuous → 4 video grants, then 1 world grant (one vid_valid gap), then video resumes. With the macro undefined, no world grant occurs until vid_req drops.
- Out-of-range video: vid_row=800 (map row 100, MAP_ROWS=96) → no ram_en; vid_valid with pixel 0 at the normal latency.
- Reset during WFLIGHT → wrld_ack never asserts; after release with wrld_req still high, a fresh grant and ack occur.
